// File: rtl/issue_pkg.sv
// Shared opcodes, queue entry and decode record for the dual-issue front end.
// Pure types/constants: no latency, no flow control.
package issue_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;

  // Entries carry the widest supported PC; the top narrows to PC_W on output.
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_MAX_W-1:0] pc;
  } issue_entry_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       writes_rd;
    logic       reads_rs1;
    logic       reads_rs2;
    logic       is_mem;
    logic       is_ctrl;
  } decode_info_t;

endpackage

// File: rtl/issue_decode.sv
// Combinational instruction classifier: register fields plus read/write/mem/ctrl flags.
// Zero latency, no flow control.
module issue_decode
  import issue_pkg::*;
(
  input  logic [31:0]  instr_i,
  output decode_info_t info_o
);

  logic [6:0] opc;
  logic       unused_fields;

  assign opc           = instr_i[6:0];
  assign unused_fields = ^{instr_i[31:25], instr_i[14:12]};

  always_comb begin
    info_o           = '0;
    info_o.rd        = instr_i[11:7];
    info_o.rs1       = instr_i[19:15];
    info_o.rs2       = instr_i[24:20];
    info_o.writes_rd = (opc != STORE) && (opc != BRANCH) && (instr_i[11:7] != 5'd0);
    info_o.reads_rs1 = (opc != LUI) && (opc != AUIPC) && (opc != JAL);
    info_o.reads_rs2 = (opc == OP) || (opc == STORE) || (opc == BRANCH);
    info_o.is_mem    = (opc == LOAD) || (opc == STORE);
    info_o.is_ctrl   = (opc == BRANCH) || (opc == JAL) || (opc == JALR);
  end

endmodule

// File: rtl/dual_issue_queue.sv
// In-order dual-issue queue: DEPTH-entry ring, 32-register scoreboard, RAW/pair-checked issue.
// Enqueue at t issues at t+1 earliest; fetch holds while fetch_accept_o=0, issue waits on issue_ready_i.
module dual_issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WB_PORTS = 2,
  parameter int PC_W     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      fetch0_valid_i,
  input  logic [31:0]               fetch0_instr_i,
  input  logic [PC_W-1:0]           fetch0_pc_i,
  input  logic                      fetch1_valid_i,
  input  logic [31:0]               fetch1_instr_i,
  input  logic [PC_W-1:0]           fetch1_pc_i,
  output logic                      fetch_accept_o,
  input  logic                      issue_ready_i,
  output logic                      issue0_valid_o,
  output logic [31:0]               issue0_instr_o,
  output logic [PC_W-1:0]           issue0_pc_o,
  output logic                      issue1_valid_o,
  output logic [31:0]               issue1_instr_o,
  output logic [PC_W-1:0]           issue1_pc_o,
  input  logic [WB_PORTS-1:0]       wb_valid_i,
  input  logic [5*WB_PORTS-1:0]     wb_rd_i,
  input  logic                      flush_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  issue_entry_t     mem_q [DEPTH];
  issue_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      sb_q, sb_d;

  issue_entry_t ent0, ent1;
  decode_info_t dec0, dec1;
  logic         blocked0, blocked1, pair_ok, accept;
  logic         iss0, iss1, enq0, enq1;
  logic [1:0]   n_iss, n_enq;
  logic         unused_bits;

  assign head1 = head_q + 1'b1;
  assign tail1 = tail_q + 1'b1;
  assign ent0  = mem_q[head_q];
  assign ent1  = mem_q[head1];

  issue_decode u_dec0 (.instr_i(ent0.instr), .info_o(dec0));
  issue_decode u_dec1 (.instr_i(ent1.instr), .info_o(dec1));

  // sb_q[0] is never set (writes_rd excludes x0), so x0 operands never block.
  assign blocked0 = (dec0.reads_rs1 && sb_q[dec0.rs1]) || (dec0.reads_rs2 && sb_q[dec0.rs2]);
  assign blocked1 = (dec1.reads_rs1 && sb_q[dec1.rs1]) || (dec1.reads_rs2 && sb_q[dec1.rs2]);

  assign pair_ok = !(dec0.writes_rd && ((dec1.reads_rs1 && (dec1.rs1 == dec0.rd)) ||
                                        (dec1.reads_rs2 && (dec1.rs2 == dec0.rd))))
                && !(dec0.writes_rd && dec1.writes_rd && (dec0.rd == dec1.rd))
                && !(dec0.is_mem && dec1.is_mem)
                && !dec0.is_ctrl;

  assign accept = (count_q <= CNT_W'(DEPTH - 2));
  assign iss0   = (count_q != '0) && !blocked0 && issue_ready_i && !flush_i;
  assign iss1   = iss0 && (count_q >= CNT_W'(2)) && !blocked1 && pair_ok;
  assign enq0   = accept && fetch0_valid_i;
  assign enq1   = enq0 && fetch1_valid_i;
  assign n_iss  = {1'b0, iss0} + {1'b0, iss1};
  assign n_enq  = {1'b0, enq0} + {1'b0, enq1};

  always_comb begin
    mem_d = mem_q;
    if (enq0) mem_d[tail_q] = '{instr: fetch0_instr_i, pc: PC_MAX_W'(fetch0_pc_i)};
    if (enq1) mem_d[tail1]  = '{instr: fetch1_instr_i, pc: PC_MAX_W'(fetch1_pc_i)};
  end

  always_comb begin
    sb_d = sb_q;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_i[p]) sb_d[wb_rd_i[p*5 +: 5]] = 1'b0;
    end
    // Sets are applied after clears so a same-cycle set/clear leaves the bit set.
    if (iss0 && dec0.writes_rd) sb_d[dec0.rd] = 1'b1;
    if (iss1 && dec1.writes_rd) sb_d[dec1.rd] = 1'b1;

    head_d  = head_q + PTR_W'(n_iss);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_iss);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      sb_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      sb_q    <= sb_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign fetch_accept_o = accept;
  assign issue0_valid_o = iss0;
  assign issue0_instr_o = ent0.instr;
  assign issue0_pc_o    = ent0.pc[PC_W-1:0];
  assign issue1_valid_o = iss1;
  assign issue1_instr_o = ent1.instr;
  assign issue1_pc_o    = ent1.pc[PC_W-1:0];
  assign count_o        = count_q;
  assign unused_bits    = ^{ent0.pc, ent1.pc, dec1.is_ctrl};

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed vector table for the multi-cycle corner cases, then random traffic
// compared against a queue/scoreboard reference model.
module tb_dual_issue_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch0_valid_i, fetch1_valid_i;
  logic [31:0] fetch0_instr_i, fetch1_instr_i;
  logic [31:0] fetch0_pc_i, fetch1_pc_i;
  logic        fetch_accept_o;
  logic        issue_ready_i;
  logic        issue0_valid_o, issue1_valid_o;
  logic [31:0] issue0_instr_o, issue1_instr_o;
  logic [31:0] issue0_pc_o, issue1_pc_o;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_rd_i;
  logic        flush_i;
  logic [3:0]  count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dual_issue_queue #(.DEPTH(8), .WB_PORTS(2), .PC_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch0_valid_i(fetch0_valid_i), .fetch0_instr_i(fetch0_instr_i), .fetch0_pc_i(fetch0_pc_i),
    .fetch1_valid_i(fetch1_valid_i), .fetch1_instr_i(fetch1_instr_i), .fetch1_pc_i(fetch1_pc_i),
    .fetch_accept_o(fetch_accept_o), .issue_ready_i(issue_ready_i),
    .issue0_valid_o(issue0_valid_o), .issue0_instr_o(issue0_instr_o), .issue0_pc_o(issue0_pc_o),
    .issue1_valid_o(issue1_valid_o), .issue1_instr_o(issue1_instr_o), .issue1_pc_o(issue1_pc_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i), .count_o(count_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Instruction builders
  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] beq(input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
  endfunction

  // Reference model: opcode classes straight from the ISA rules
  logic [31:0] msb;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t mq[$];

  function automatic bit m_wr(input logic [31:0] i);
    return i[6:0] != 7'b0100011 && i[6:0] != 7'b1100011 && i[11:7] != 5'd0;
  endfunction
  function automatic bit m_r1(input logic [31:0] i);
    return !(i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction
  function automatic bit m_r2(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit m_mem(input logic [31:0] i);
    return i[6:0] inside {7'b0000011, 7'b0100011};
  endfunction
  function automatic bit m_ctrl(input logic [31:0] i);
    return i[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
  endfunction
  function automatic bit m_reads(input logic [31:0] i, input logic [4:0] r);
    return (m_r1(i) && i[19:15] == r) || (m_r2(i) && i[24:20] == r);
  endfunction
  function automatic bit m_blocked(input logic [31:0] i);
    return (m_r1(i) && i[19:15] != 0 && msb[i[19:15]]) ||
           (m_r2(i) && i[24:20] != 0 && msb[i[24:20]]);
  endfunction
  function automatic bit m_pair_ok(input logic [31:0] a, input logic [31:0] b);
    if (m_ctrl(a)) return 0;
    if (m_mem(a) && m_mem(b)) return 0;
    if (m_wr(a) && m_wr(b) && a[11:7] == b[11:7]) return 0;
    if (m_wr(a) && m_reads(b, a[11:7])) return 0;
    return 1;
  endfunction

  typedef struct {
    bit rst; bit f0v; logic [31:0] i0; bit f1v; logic [31:0] i1; bit rdy;
    bit [1:0] wbv; bit [4:0] wb0; bit [4:0] wb1; bit flush; bit chk;
    bit eacc; bit ei0; bit ei1; int ecnt;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input bit rst, input bit f0v, input logic [31:0] i0, input bit f1v,
                     input logic [31:0] i1, input bit rdy, input bit [1:0] wbv, input bit [4:0] wb0,
                     input bit [4:0] wb1, input bit flush, input bit chk, input bit eacc,
                     input bit ei0, input bit ei1, input int ecnt);
    vec_t v;
    v = '{rst, f0v, i0, f1v, i1, rdy, wbv, wb0, wb1, flush, chk, eacc, ei0, ei1, ecnt};
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] n;
    logic [6:0]  opcs [9];
    longint      last_pc;
    logic [31:0] pc_ctr;
    bit          e_acc, e0, e1;
    logic [31:0] nsb;

    n = add(0, 0, 0);
    //   rst f0v i0          f1v i1           rdy wbv wb0 wb1 fl chk  acc i0 i1 cnt
    row(1, 0, n,           0, n,           1, 0, 0,  0,  0, 0,  1, 0, 0, 0);
    row(0, 1, add(1,2,3),  1, add(4,5,6),  1, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 1, 2);
    row(0, 1, add(7,1,0),  1, add(8,4,0),  1, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 0, n,           0, n,           1, 1, 1,  0,  0, 1,  1, 0, 0, 2);
    row(0, 0, n,           0, n,           1, 1, 4,  0,  0, 1,  1, 1, 0, 2);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 0, 1);
    row(0, 0, n,           0, n,           1, 3, 7,  8,  0, 1,  1, 0, 0, 0);
    row(0, 1, add(1,2,3),  1, add(2,1,0),  1, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 0, 2);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 0, 0, 1);
    row(0, 0, n,           0, n,           1, 1, 1,  0,  0, 1,  1, 0, 0, 1);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 0, 1);
    row(0, 0, n,           0, n,           1, 1, 2,  0,  0, 1,  1, 0, 0, 0);
    row(0, 1, lw(5,6),     1, sw(7,8),     1, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 0, 2);
    row(0, 1, beq(0,0),    1, add(10,0,0), 1, 0, 0,  0,  0, 1,  1, 1, 0, 1);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 0, 2);
    row(0, 0, n,           0, n,           1, 1, 5,  0,  0, 1,  1, 1, 0, 1);
    row(0, 0, n,           0, n,           1, 1, 10, 0,  0, 1,  1, 0, 0, 0);
    row(0, 1, n,           1, n,           0, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 1, n,           1, n,           0, 0, 0,  0,  0, 1,  1, 0, 0, 2);
    row(0, 1, n,           1, n,           0, 0, 0,  0,  0, 1,  1, 0, 0, 4);
    row(0, 1, n,           1, n,           0, 0, 0,  0,  0, 1,  1, 0, 0, 6);
    row(0, 1, n,           1, n,           1, 0, 0,  0,  0, 1,  0, 1, 1, 8);
    row(0, 1, n,           0, n,           0, 0, 0,  0,  0, 1,  1, 0, 0, 6);
    row(0, 1, n,           1, n,           1, 0, 0,  0,  0, 1,  0, 1, 1, 7);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 1, 5);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 1, 3);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 0, 1);
    row(0, 1, add(9,0,0),  0, n,           1, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 1, add(13,9,0), 1, n,           1, 0, 0,  0,  0, 1,  1, 1, 0, 1);
    row(0, 1, n,           1, n,           1, 0, 0,  0,  0, 1,  1, 0, 0, 2);
    row(0, 1, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 0, 0, 4);
    row(0, 1, n,           1, n,           1, 0, 0,  0,  1, 1,  1, 0, 0, 5);
    row(0, 1, add(14,9,0), 1, n,           1, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 0, 0, 2);
    row(0, 0, n,           0, n,           1, 1, 9,  0,  0, 1,  1, 0, 0, 2);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 1, 2);
    row(0, 0, n,           0, n,           1, 1, 14, 0,  0, 1,  1, 0, 0, 0);
    row(0, 1, add(15,0,0), 1, add(16,0,0), 0, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 1, n,           1, n,           0, 0, 0,  0,  0, 1,  1, 0, 0, 2);
    row(0, 1, n,           1, n,           0, 0, 0,  0,  0, 1,  1, 0, 0, 4);
    row(1, 1, n,           1, n,           1, 0, 0,  0,  0, 1,  1, 1, 1, 6);
    row(0, 1, add(17,15,0),1, add(18,16,0),1, 0, 0,  0,  0, 1,  1, 0, 0, 0);
    row(0, 0, n,           0, n,           1, 0, 0,  0,  0, 1,  1, 1, 1, 2);
    row(0, 0, n,           0, n,           1, 3, 17, 18, 0, 1,  1, 0, 0, 0);

    last_pc = -1;
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk_i);
      rst_i          = tbl[r].rst;
      fetch0_valid_i = tbl[r].f0v;
      fetch0_instr_i = tbl[r].i0;
      fetch0_pc_i    = 32'h1000 + 32'(r) * 8;
      fetch1_valid_i = tbl[r].f1v;
      fetch1_instr_i = tbl[r].i1;
      fetch1_pc_i    = 32'h1004 + 32'(r) * 8;
      issue_ready_i  = tbl[r].rdy;
      wb_valid_i     = tbl[r].wbv;
      wb_rd_i        = {tbl[r].wb1, tbl[r].wb0};
      flush_i        = tbl[r].flush;
      #1;
      if (tbl[r].chk) begin
        chk($sformatf("row%0d_accept", r), 64'(fetch_accept_o), 64'(tbl[r].eacc));
        chk($sformatf("row%0d_issue0", r), 64'(issue0_valid_o), 64'(tbl[r].ei0));
        chk($sformatf("row%0d_issue1", r), 64'(issue1_valid_o), 64'(tbl[r].ei1));
        chk($sformatf("row%0d_count", r), 64'(count_o), 64'(tbl[r].ecnt));
        if (issue0_valid_o) begin
          chk($sformatf("row%0d_pc0_order", r), 64'(longint'(issue0_pc_o) > last_pc), 64'd1);
          last_pc = longint'(issue0_pc_o);
        end
        if (issue1_valid_o) begin
          chk($sformatf("row%0d_pc1_order", r), 64'(longint'(issue1_pc_o) > last_pc), 64'd1);
          last_pc = longint'(issue1_pc_o);
        end
      end
    end

    opcs[0] = 7'b0000011; opcs[1] = 7'b0100011; opcs[2] = 7'b1100011;
    opcs[3] = 7'b1101111; opcs[4] = 7'b1100111; opcs[5] = 7'b0110111;
    opcs[6] = 7'b0010111; opcs[7] = 7'b0110011; opcs[8] = 7'b0010011;
    msb    = '0;
    pc_ctr = 32'h8000_0000;
    mq.delete();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      rst_i          = (c == 0) || ($urandom_range(0, 199) == 0);
      flush_i        = ($urandom_range(0, 39) == 0);
      issue_ready_i  = ($urandom_range(0, 3) != 0);
      fetch0_valid_i = ($urandom_range(0, 2) != 0);
      fetch1_valid_i = fetch0_valid_i && ($urandom_range(0, 1) == 1);
      fetch0_instr_i = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        3'($urandom), 5'($urandom_range(0, 7)), opcs[$urandom_range(0, 8)]};
      fetch1_instr_i = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        3'($urandom), 5'($urandom_range(0, 7)), opcs[$urandom_range(0, 8)]};
      fetch0_pc_i    = pc_ctr;
      fetch1_pc_i    = pc_ctr + 4;
      pc_ctr         = pc_ctr + 8;
      wb_valid_i     = 2'($urandom);
      wb_rd_i        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;

      e_acc = (mq.size() <= 6);
      e0 = (mq.size() >= 1) && issue_ready_i && !flush_i && !m_blocked(mq[0].instr);
      e1 = e0 && (mq.size() >= 2) && !m_blocked(mq[1].instr) &&
           m_pair_ok(mq[0].instr, mq[1].instr);

      chk("rnd_accept", 64'(fetch_accept_o), 64'(e_acc));
      chk("rnd_issue0", 64'(issue0_valid_o), 64'(e0));
      chk("rnd_issue1", 64'(issue1_valid_o), 64'(e1));
      chk("rnd_count", 64'(count_o), 64'(mq.size()));
      if (e0) begin
        chk("rnd_instr0", 64'(issue0_instr_o), 64'(mq[0].instr));
        chk("rnd_pc0", 64'(issue0_pc_o), 64'(mq[0].pc));
      end
      if (e1) begin
        chk("rnd_instr1", 64'(issue1_instr_o), 64'(mq[1].instr));
        chk("rnd_pc1", 64'(issue1_pc_o), 64'(mq[1].pc));
      end

      if (rst_i) begin
        mq.delete();
        msb = '0;
      end else begin
        nsb = msb;
        if (wb_valid_i[0]) nsb[wb_rd_i[4:0]] = 1'b0;
        if (wb_valid_i[1]) nsb[wb_rd_i[9:5]] = 1'b0;
        if (e0 && m_wr(mq[0].instr)) nsb[mq[0].instr[11:7]] = 1'b1;
        if (e1 && m_wr(mq[1].instr)) nsb[mq[1].instr[11:7]] = 1'b1;
        msb = nsb;
        if (flush_i) begin
          mq.delete();
        end else begin
          if (e0) void'(mq.pop_front());
          if (e1) void'(mq.pop_front());
          if (e_acc && fetch0_valid_i) mq.push_back('{fetch0_instr_i, fetch0_pc_i});
          if (e_acc && fetch1_valid_i) mq.push_back('{fetch1_instr_i, fetch1_pc_i});
        end
      end
    end

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
- Parametrised in-order dual-issue front end that replaces the fixed pass-through issue wrapper.
- Buffers up to two fetched instructions per cycle in a DEPTH-entry circular queue.
- Tracks outstanding destination registers in a 32-entry scoreboard.
- Issues 0, 1 or 2 instructions per cycle under RAW and pairing rules, with backend stall and pipeline flush.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.
- WB_PORTS, 2, number of writeback scoreboard-clear ports; 1..4.
- PC_W, 32, width of PC fields.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- fetch0_valid_i  in  1  slot-0 instruction valid (older).
- fetch0_instr_i  in  32  slot-0 instruction.
- fetch0_pc_i  in  PC_W  slot-0 PC.
- fetch1_valid_i  in  1  slot-1 instruction valid; only legal with fetch0_valid_i.
- fetch1_instr_i  in  32  slot-1 instruction.
- fetch1_pc_i  in  PC_W  slot-1 PC.
- fetch_accept_o  out  1  queue can take a full pair this cycle.
- issue_ready_i  in  1  backend accepts issue this cycle.
- issue0_valid_o  out  1  oldest instruction issues.
- issue0_instr_o  out  32  its instruction.
- issue0_pc_o  out  PC_W  its PC.
- issue1_valid_o  out  1  second-oldest instruction issues as pair.
- issue1_instr_o  out  32  its instruction.
- issue1_pc_o  out  PC_W  its PC.
- wb_valid_i  in  WB_PORTS  writeback valid per port.
- wb_rd_i  in  5*WB_PORTS  writeback register index per port.
- flush_i  in  1  discard all queued instructions.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_i=1 at posedge):
  - head=tail=count=0; scoreboard all zero.
  - issue*_valid_o=0; count_o=0; fetch_accept_o=1.
- Accept:
  - fetch_accept_o = (count <= DEPTH-2), combinational.
  - Enqueue happens only when fetch_accept_o=1; slot 0 is written before slot 1, and tail advances by the number of valid slots.
  - Fetch valids with fetch_accept_o=0 are ignored; fetch must hold them.
- Decode (combinational, per queue entry), opcode = instr[6:0]:
  - writes_rd: opcode is not STORE 0100011 and not BRANCH 1100011, and rd != 0.
  - reads_rs1: opcode is not LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - reads_rs2: opcode is OP 0110011, STORE or BRANCH.
  - is_mem: LOAD 0000011 or STORE.
  - is_ctrl: BRANCH, JAL, or JALR 1100111.
- Hazards:
  - An entry is blocked if scoreboard[rs1] is set and reads_rs1 holds, or scoreboard[rs2] is set and reads_rs2 holds.
  - x0 is never blocked.
- Issue, evaluated combinationally from the registered state:
  - issue0_valid_o = count>=1 & head not blocked & issue_ready_i & !flush_i.
  - issue1_valid_o = issue0_valid_o & count>=2 & entry head+1 not blocked & none of the pairing violations below.
  - Pairing violations:
    - head+1 reads the rd of head (RAW within the pair).
    - head and head+1 have the same rd, both write rd (WAW).
    - Both entries are is_mem.
    - head is is_ctrl.
- Latency:
  - An instruction enqueued in cycle t issues no earlier than t+1.
  - There is no bypass from fetch to issue.
- Scoreboard:
  - On an issue posedge, set bit rd for each issued entry with writes_rd.
  - Clear bit wb_rd for each wb_valid_i port.
  - If a set and a clear target the same register in the same cycle, set wins.
  - The scoreboard is registered; a writeback in cycle t unblocks a dependent instruction in cycle t+1 (no same-cycle bypass).
- Pointers:
  - head advances by the number issued (0/1/2); tail advances by the number enqueued.
  - Both wrap modulo DEPTH.
  - count_next = count + enq - iss; simultaneous enqueue and issue are legal at any occupancy.
- Flush (flush_i=1):
  - No issue that cycle; head=tail=count=0 next cycle; enqueue that cycle is dropped.
  - The scoreboard is retained, because in-flight ops still write back; writeback clears still apply that cycle.
- Reset overrides flush and every other event.

Decomposition:
- Shared package issue_pkg holds:
  - Opcode localparams: LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP.
  - Typedef issue_entry_t {instr, pc}.
  - Typedef decode_info_t {rd, rs1, rs2, writes_rd, reads_rs1, reads_rs2, is_mem, is_ctrl}.
- One sub-module, issue_decode: purely combinational, maps a 32-bit instruction to decode_info_t; instantiated twice (for head and head+1).

Test Plan:
- Pair handling: reset, then push a pair ADD x1,x2,x3 / ADD x4,x5,x6.
  - Next cycle both issue valids are 1; count returns to 0.
  - Scoreboard bits 1 and 4 are set.
- Intra-pair RAW: push ADD x1,.. / ADD x2,x1,x0.
  - Cycle 1: only issue0 valid.
  - Cycle 2: the second instruction stays blocked until wb_rd=1 is asserted, then issues one cycle later.
- Memory pairing: push LW x5,0(x6) / SW x7,0(x8) with a clean scoreboard.
  - They issue in consecutive cycles, never as a pair.
  - A BEQ at head never has an issue1 partner.
- Full and wrap: hold issue_ready_i=0 and push 4 pairs with DEPTH=8.
  - count_o reaches 8; fetch_accept_o drops to 0 at count 7 and 8.
  - Then release issue_ready_i: 8 instructions drain in order across the pointer wrap, with PCs monotonic.
- Flush: with count=5 and scoreboard bit 9 set, assert flush_i alongside a fetch pair.
  - Next cycle count_o=0 and no issue occurs.
  - Bit 9 is still set until a wb clear.
- Reset priority: assert rst_i while count=6 and a pair is issuing.
  - Next cycle all outputs are at their reset values and the scoreboard is clear.
